// File: rtl/multicycle_cpu_core_pkg.sv
// Shared definitions for the multi-cycle TSC-ISA core: word size, opcode and
// function-code constants, FSM state encoding and ALU operation encoding.
package multicycle_cpu_core_pkg;

  localparam int WORD_SIZE = 16;

  // Opcodes, instruction bits [15:12]
  localparam logic [3:0] OP_BNE = 4'd0;
  localparam logic [3:0] OP_BEQ = 4'd1;
  localparam logic [3:0] OP_BGZ = 4'd2;
  localparam logic [3:0] OP_BLZ = 4'd3;
  localparam logic [3:0] OP_ADI = 4'd4;
  localparam logic [3:0] OP_ORI = 4'd5;
  localparam logic [3:0] OP_LHI = 4'd6;
  localparam logic [3:0] OP_LWD = 4'd7;
  localparam logic [3:0] OP_SWD = 4'd8;
  localparam logic [3:0] OP_JMP = 4'd9;
  localparam logic [3:0] OP_JAL = 4'd10;
  localparam logic [3:0] OP_ALU = 4'd15;

  // Function codes for OP_ALU, instruction bits [5:0]
  localparam logic [5:0] FN_ADD = 6'd0;
  localparam logic [5:0] FN_SUB = 6'd1;
  localparam logic [5:0] FN_AND = 6'd2;
  localparam logic [5:0] FN_ORR = 6'd3;
  localparam logic [5:0] FN_NOT = 6'd4;
  localparam logic [5:0] FN_TCP = 6'd5;
  localparam logic [5:0] FN_SHL = 6'd6;
  localparam logic [5:0] FN_SHR = 6'd7;
  localparam logic [5:0] FN_JPR = 6'd25;
  localparam logic [5:0] FN_JRL = 6'd26;
  localparam logic [5:0] FN_WWD = 6'd28;
  localparam logic [5:0] FN_HLT = 6'd29;

  typedef enum logic [2:0] {
    S_IF     = 3'd0,
    S_EX     = 3'd1,
    S_MEM_RD = 3'd2,
    S_MEM_WR = 3'd3,
    S_HALT   = 3'd4,
    S_ERROR  = 3'd5
  } state_t;

  // Encoded to match FN_ADD..FN_SHR so func[2:0] maps directly.
  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_NOT = 3'd4,
    ALU_TCP = 3'd5,
    ALU_SHL = 3'd6,
    ALU_SHR = 3'd7
  } alu_op_t;

  function automatic logic [WORD_SIZE-1:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

endpackage

// File: rtl/multicycle_cpu_core_if.sv
// Memory handshake bundle between the core (master) and unified memory (slave).
//   readM/address  : read request; held until the edge where inputReady=1,
//                    which is the edge the read data is consumed.
//   writeM/address : write request; held until the edge where ackOutput=1,
//                    which is the edge the write is considered accepted.
// The shared data bus itself is a separate inout port on the core.
interface multicycle_cpu_core_if;
  import multicycle_cpu_core_pkg::*;

  logic                 readM;
  logic                 writeM;
  logic [WORD_SIZE-1:0] address;
  logic                 inputReady;
  logic                 ackOutput;

  modport master (output readM, writeM, address, input inputReady, ackOutput);
  modport slave  (input readM, writeM, address, output inputReady, ackOutput);
endinterface

// File: rtl/multicycle_cpu_core_alu.sv
// Combinational ALU shared by R-type ops, ADI, ORI and load/store address
// generation.
//   op     : operation select
//   a, b   : operands (unary ops use a only)
//   result : 16-bit result, carry/overflow discarded
module multicycle_cpu_core_alu
  import multicycle_cpu_core_pkg::*;
(
  input  alu_op_t              op,
  input  logic [WORD_SIZE-1:0] a,
  input  logic [WORD_SIZE-1:0] b,
  output logic [WORD_SIZE-1:0] result
);

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_NOT: result = ~a;
      ALU_TCP: result = ~a + 16'd1;
      ALU_SHL: result = {a[WORD_SIZE-2:0], 1'b0};
      ALU_SHR: result = {a[WORD_SIZE-1], a[WORD_SIZE-1:1]};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_cpu_core.sv
// Multi-cycle 16-bit TSC-ISA core: IF -> EX -> (MEM_RD | MEM_WR) -> IF.
//   clk, reset  : clock, synchronous active-high reset
//   bus         : readM/writeM/address out, inputReady/ackOutput in
//   data        : shared bus, driven only while writeM=1
//   output_port : value of the last WWD
//   num_inst    : retired-instruction count (wraps)
//   is_halted   : HLT retired; mem_error: handshake timeout
//   fsm_state   : current FSM state for observation
module multicycle_cpu_core
  import multicycle_cpu_core_pkg::*;
#(
  parameter logic [WORD_SIZE-1:0] RESET_PC       = 16'h0000,
  parameter int unsigned          TIMEOUT_CYCLES = 0,
  parameter int                   NUM_INST_W     = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  multicycle_cpu_core_if.master  bus,
  inout  wire  [WORD_SIZE-1:0]   data,
  output logic [WORD_SIZE-1:0]   output_port,
  output logic [NUM_INST_W-1:0]  num_inst,
  output logic                   is_halted,
  output logic                   mem_error,
  output state_t                 fsm_state
);

  localparam logic [31:0] TIMEOUT_LAST =
    (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);
  localparam logic [NUM_INST_W-1:0] INST_ONE = NUM_INST_W'(1);

  logic [WORD_SIZE-1:0] pc, ir, wdata;
  logic [WORD_SIZE-1:0] regs [4];
  logic [31:0]          wait_cnt;

  assign data = bus.writeM ? wdata : 'z;

  // Instruction fields
  logic [3:0]           opcode;
  logic [1:0]           rs_idx, rt_idx, rd_idx;
  logic [5:0]           func;
  logic [WORD_SIZE-1:0] rs_val, rt_val, sext_imm, zext_imm;

  assign opcode   = ir[15:12];
  assign rs_idx   = ir[11:10];
  assign rt_idx   = ir[9:8];
  assign rd_idx   = ir[7:6];
  assign func     = ir[5:0];
  assign rs_val   = regs[rs_idx];
  assign rt_val   = regs[rt_idx];
  assign sext_imm = sext8(ir[7:0]);
  assign zext_imm = {8'h00, ir[7:0]};

  alu_op_t              alu_op;
  logic [WORD_SIZE-1:0] alu_b, alu_result;

  multicycle_cpu_core_alu u_alu (
    .op     (alu_op),
    .a      (rs_val),
    .b      (alu_b),
    .result (alu_result)
  );

  // Timeout only bites when enabled; a same-edge handshake is checked first.
  logic wait_expired;
  assign wait_expired = (TIMEOUT_CYCLES != 0) && (wait_cnt == TIMEOUT_LAST);

  // EX decode; only consumed while fsm_state == S_EX.
  logic                 wr_en, is_wwd;
  logic [1:0]           wr_idx;
  logic [WORD_SIZE-1:0] wr_val, next_pc;
  state_t               ex_next;

  always_comb begin
    alu_op  = ALU_ADD;
    alu_b   = sext_imm;
    wr_en   = 1'b0;
    wr_idx  = rt_idx;
    wr_val  = alu_result;
    is_wwd  = 1'b0;
    next_pc = pc;
    ex_next = S_IF;
    case (opcode)
      OP_BNE: if (rs_val != rt_val)          next_pc = pc + sext_imm;
      OP_BEQ: if (rs_val == rt_val)          next_pc = pc + sext_imm;
      OP_BGZ: if ($signed(rs_val) > 16'sd0)  next_pc = pc + sext_imm;
      OP_BLZ: if (rs_val[WORD_SIZE-1])       next_pc = pc + sext_imm;
      OP_ADI: wr_en = 1'b1;
      OP_ORI: begin
        alu_op = ALU_OR;
        alu_b  = zext_imm;
        wr_en  = 1'b1;
      end
      OP_LHI: begin
        wr_en  = 1'b1;
        wr_val = {ir[7:0], 8'h00};
      end
      OP_LWD: ex_next = S_MEM_RD;
      OP_SWD: ex_next = S_MEM_WR;
      OP_JMP: next_pc = {pc[15:12], ir[11:0]};
      OP_JAL: begin
        next_pc = {pc[15:12], ir[11:0]};
        wr_en   = 1'b1;
        wr_idx  = 2'd2;
        wr_val  = pc;
      end
      OP_ALU: begin
        alu_op = alu_op_t'(func[2:0]);
        alu_b  = rt_val;
        case (func)
          FN_ADD, FN_SUB, FN_AND, FN_ORR, FN_NOT, FN_TCP, FN_SHL, FN_SHR: begin
            wr_en  = 1'b1;
            wr_idx = rd_idx;
          end
          FN_JPR: next_pc = rs_val;
          FN_JRL: begin
            next_pc = rs_val;       // rs_val is the pre-write value
            wr_en   = 1'b1;
            wr_idx  = 2'd2;
            wr_val  = pc;
          end
          FN_WWD:  is_wwd  = 1'b1;
          FN_HLT:  ex_next = S_HALT;
          default: ;                // undefined func: NOP
        endcase
      end
      default: ;                    // undefined opcode: NOP
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_state   <= S_IF;
      pc          <= RESET_PC;
      ir          <= '0;
      wdata       <= '0;
      wait_cnt    <= '0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
      bus.readM   <= 1'b0;
      bus.writeM  <= 1'b0;
      bus.address <= '0;
      output_port <= '0;
      num_inst    <= '0;
      is_halted   <= 1'b0;
      mem_error   <= 1'b0;
    end else begin
      case (fsm_state)
        S_IF: begin
          if (!bus.readM) begin
            // First fetch after reset, or after a memory op: raise the request.
            bus.readM   <= 1'b1;
            bus.address <= pc;
            wait_cnt    <= '0;
          end else if (bus.inputReady) begin
            ir        <= data;
            bus.readM <= 1'b0;
            pc        <= pc + 16'd1;
            fsm_state <= S_EX;
          end else if (wait_expired) begin
            bus.readM <= 1'b0;
            mem_error <= 1'b1;
            fsm_state <= S_ERROR;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        S_EX: begin
          if (wr_en)  regs[wr_idx] <= wr_val;
          if (is_wwd) output_port  <= rs_val;
          pc       <= next_pc;
          wait_cnt <= '0;
          case (ex_next)
            S_MEM_RD: begin
              bus.readM   <= 1'b1;
              bus.address <= alu_result;
              fsm_state   <= S_MEM_RD;
            end
            S_MEM_WR: begin
              bus.writeM  <= 1'b1;
              bus.address <= alu_result;
              wdata       <= rt_val;
              fsm_state   <= S_MEM_WR;
            end
            S_HALT: begin
              num_inst  <= num_inst + INST_ONE;
              is_halted <= 1'b1;
              fsm_state <= S_HALT;
            end
            default: begin
              // Retire and issue the next fetch on the same edge.
              num_inst    <= num_inst + INST_ONE;
              bus.readM   <= 1'b1;
              bus.address <= next_pc;
              fsm_state   <= S_IF;
            end
          endcase
        end
        S_MEM_RD: begin
          if (bus.inputReady) begin
            regs[rt_idx] <= data;
            bus.readM    <= 1'b0;
            num_inst     <= num_inst + INST_ONE;
            fsm_state    <= S_IF;
          end else if (wait_expired) begin
            bus.readM <= 1'b0;
            mem_error <= 1'b1;
            fsm_state <= S_ERROR;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        S_MEM_WR: begin
          if (bus.ackOutput) begin
            bus.writeM <= 1'b0;
            num_inst   <= num_inst + INST_ONE;
            fsm_state  <= S_IF;
          end else if (wait_expired) begin
            bus.writeM <= 1'b0;
            mem_error  <= 1'b1;
            fsm_state  <= S_ERROR;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        default: ;  // S_HALT / S_ERROR hold until reset
      endcase
    end
  end

endmodule
